lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the pipeline MEM stage and the byte-addressed data RAM.
- Accepts one load/store request at a time over a valid/ready handshake and drives the RAM write/address/data/store-size port.
- Splits 64-bit stores into two word writes, since the RAM writes at most 4 bytes per cycle.
- Sign/zero-extends load data and returns it with a one-cycle response pulse.

Parameters:
- XLEN, `XLEN_64b, 2-bit width encoding; data/address width W = 1<<(XLEN+4) (32 or 64).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_clk_en  in  1  clock enable; low freezes all state and registered outputs
- i_req_valid  in  1  request present
- o_req_ready  out  1  controller idle, can accept
- i_req_write  in  1  1=store, 0=load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 double
- i_req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- i_req_addr  in  W  byte address
- i_req_wdata  in  W  store data, LSB-aligned
- o_rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- o_rsp_rdata  out  W  extended load data; 0 for stores
- o_mem_write  out  1  RAM write strobe
- o_mem_addr  out  W  RAM byte address
- o_mem_wdata  out  W  RAM write data
- o_store_byte  out  1  RAM byte-store select
- o_store_half  out  1  RAM half-store select
- i_mem_rdata  in  W  RAM combinational read data at o_mem_addr, little-endian

Behaviour:
- States: IDLE, ACC, ACC_HI, DONE. All transitions are qualified by i_clk_en; with i_clk_en low, state and every registered output hold.
- IDLE:
  - o_req_ready=1 (combinational, state==IDLE only).
  - On i_req_valid: latch write, size, unsigned, addr and wdata; go to ACC.
- ACC:
  - o_mem_addr = latched addr.
  - Store: o_mem_write=1, o_mem_wdata=latched wdata. Byte sets o_store_byte=1; half sets o_store_half=1; word and double set both 0.
  - Double store (XLEN 64): write the low word here, then go to ACC_HI.
  - All other cases go to DONE.
  - Load: o_mem_write=0. Sample i_mem_rdata this cycle and register the extended value into o_rsp_rdata.
- ACC_HI:
  - o_mem_write=1, o_mem_addr = addr+4, o_mem_wdata low 32 bits = latched wdata[63:32], both size selects 0; go to DONE.
- DONE: o_rsp_valid=1 for exactly one enabled cycle; return to IDLE. A new request is accepted no earlier than the following cycle.
- Load extension from i_mem_rdata:
  - byte bits[7:0]; half bits[15:0]; word bits[31:0].
  - Sign-extend to W unless unsigned.
  - Double returns the full 64 bits.
- XLEN 32: size 11 is treated as word, with no ACC_HI.
- Latency (enabled cycles, request accepted at N):
  - Load/byte/half/word store: RAM access at N+1, o_rsp_valid at N+2.
  - Double store: low word at N+1, high word at N+2, o_rsp_valid at N+3.
- Outside ACC/ACC_HI, o_mem_write, o_store_byte and o_store_half are 0. o_mem_addr and o_mem_wdata hold their last values.
- Address arithmetic is modulo 2^W; addr+4 wraps.
- Reset values: state IDLE, o_rsp_valid 0, o_rsp_rdata 0, o_mem_write 0, o_mem_addr 0, o_mem_wdata 0, o_store_byte 0, o_store_half 0. o_req_ready is 1 in the cycle after reset.
- Reset mid-operation: aborts immediately and no response is issued. A double store reset in ACC_HI leaves the low word written and the high word unwritten.
- i_req_valid is ignored outside IDLE. The requester must hold the request until it sees o_req_ready.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output o_misalign (1 bit, reset 0).
  - A request whose addr is not a multiple of its size (half addr[0]; word addr[1:0]; double addr[2:0]) goes IDLE→DONE with no RAM access.
  - In DONE it drives o_misalign=1 with o_rsp_valid, and o_rsp_rdata=0.
- Not defined: no port. Misaligned accesses are executed byte-exactly as aligned ones, since the RAM is byte-addressed.

Test Plan:
- Reset, then store word wdata=0xDEADBEEF at addr 0x100 → at N+1 o_mem_write=1, addr 0x100, both selects 0; o_rsp_valid at N+2; reload returns 0xFFFFFFFFDEADBEEF (XLEN 64).
- Store double 0x1122334455667788 at 0x200 → writes 0x55667788@0x200 then 0x11223344@0x204; o_rsp_valid at N+3; load double returns 0x1122334455667788.
- RAM byte 0x80 at 0x10: LB → 0xFFFFFFFFFFFFFF80; LBU → 0x80. Half 0x8001: LH → 0xFFFFFFFFFFFF8001.
- Hold i_clk_en=0 for 3 cycles in ACC_HI → no state change; completion is delayed exactly 3 cycles; data is correct.
- Assert i_rst in ACC_HI of a double store → no o_rsp_valid; o_req_ready=1 next cycle; only the low word is written.
- With LSU_MISALIGN_TRAP_EN, load word at 0x102 → no RAM access; o_misalign=1 and o_rsp_valid=1 at N+1. Without the macro, the same request returns the bytes at 0x102..0x105.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a byte-addressed data RAM.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

module lsu_mem_ctrl #(
   parameter logic [1:0] XLEN = `XLEN_64b
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_clk_en,
   input  logic                                i_req_valid,
   output logic                                o_req_ready,
   input  logic                                i_req_write,
   input  logic [1:0]                          i_req_size,
   input  logic                                i_req_unsigned,
   input  logic [(1 << (int'(XLEN) + 4))-1:0]  i_req_addr,
   input  logic [(1 << (int'(XLEN) + 4))-1:0]  i_req_wdata,
   output logic                                o_rsp_valid,
   output logic [(1 << (int'(XLEN) + 4))-1:0]  o_rsp_rdata,
   output logic                                o_mem_write,
   output logic [(1 << (int'(XLEN) + 4))-1:0]  o_mem_addr,
   output logic [(1 << (int'(XLEN) + 4))-1:0]  o_mem_wdata,
   output logic                                o_store_byte,
   output logic                                o_store_half,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic                                o_misalign,
`endif
   input  logic [(1 << (int'(XLEN) + 4))-1:0]  i_mem_rdata
);

   localparam int W = 1 << (int'(XLEN) + 4);
   localparam logic IS64 = (W == 64);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACC    = 2'd1,
      ST_ACC_HI = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t         state_r, state_s;
   logic           wr_r, uns_r;
   logic [1:0]     size_r;
   logic [W-1:0]   addr_r, wdata_r;
   logic           rsp_valid_r, rsp_valid_s;
   logic [W-1:0]   rsp_rdata_r, rsp_rdata_s;
   logic           mem_write_r, mem_write_s;
   logic [W-1:0]   mem_addr_r, mem_addr_s;
   logic [W-1:0]   mem_wdata_r, mem_wdata_s;
   logic           byte_r, byte_s, half_r, half_s;
   logic [1:0]     req_size_s;
   logic           trap_s;
   logic [31:0]    wdata_hi_s;
`ifdef LSU_MISALIGN_TRAP_EN
   logic           misalign_r, misalign_s;
`endif

   // A 32-bit datapath has no double access; size 11 degrades to word.
   function automatic logic [1:0] norm_size(input logic [1:0] sz);
      if (!IS64 && (sz == 2'd3)) begin
         return 2'd2;
      end else begin
         return sz;
      end
   endfunction

   function automatic logic [W-1:0] load_extend(input logic [W-1:0] d,
                                                input logic [1:0] sz,
                                                input logic uns);
      logic [63:0] d64;
      logic [63:0] r;
      d64 = 64'(d);
      case (sz)
         2'd0:    r = {{56{d64[7]  & ~uns}}, d64[7:0]};
         2'd1:    r = {{48{d64[15] & ~uns}}, d64[15:0]};
         2'd2:    r = {{32{d64[31] & ~uns}}, d64[31:0]};
         default: r = d64;
      endcase
      return r[W-1:0];
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
      case (sz)
         2'd0:    return 1'b0;
         2'd1:    return a[0];
         2'd2:    return (a[1:0] != 2'd0);
         default: return (a[2:0] != 3'd0);
      endcase
   endfunction
`endif

   assign req_size_s = norm_size(i_req_size);
   assign wdata_hi_s = wdata_r[W-1 -: 32];

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_s = is_misaligned(req_size_s, i_req_addr[2:0]);
`else
   assign trap_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
      end else if (i_clk_en) begin
         state_r <= state_s;
      end
   end

   // Next-state and next registered-output values.
   always_comb begin
      state_s     = state_r;
      rsp_valid_s = 1'b0;
      rsp_rdata_s = rsp_rdata_r;
      mem_write_s = 1'b0;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      byte_s      = 1'b0;
      half_s      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (i_req_valid) begin
               if (trap_s) begin
                  state_s     = ST_DONE;
                  rsp_valid_s = 1'b1;
                  rsp_rdata_s = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                  misalign_s  = 1'b1;
`endif
               end else begin
                  state_s     = ST_ACC;
                  mem_write_s = i_req_write;
                  mem_addr_s  = i_req_addr;
                  mem_wdata_s = i_req_write ? i_req_wdata : mem_wdata_r;
                  byte_s      = i_req_write & (req_size_s == 2'd0);
                  half_s      = i_req_write & (req_size_s == 2'd1);
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (IS64 && wr_r && (size_r == 2'd3)) begin
               state_s     = ST_ACC_HI;
               mem_write_s = 1'b1;
               mem_addr_s  = addr_r + W'(3'd4);
               mem_wdata_s = W'(wdata_hi_s);
            end else begin
               state_s     = ST_DONE;
               rsp_valid_s = 1'b1;
               rsp_rdata_s = wr_r ? '0 : load_extend(i_mem_rdata, size_r, uns_r);
            end
         end
         ST_ACC_HI: begin
            state_s     = ST_DONE;
            rsp_valid_s = 1'b1;
            rsp_rdata_s = '0;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Request latch and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_r        <= 1'b0;
         uns_r       <= 1'b0;
         size_r      <= 2'd0;
         addr_r      <= '0;
         wdata_r     <= '0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= '0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         byte_r      <= 1'b0;
         half_r      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_r  <= 1'b0;
`endif
      end else if (i_clk_en) begin
         if ((state_r == ST_IDLE) && i_req_valid) begin
            wr_r    <= i_req_write;
            uns_r   <= i_req_unsigned;
            size_r  <= req_size_s;
            addr_r  <= i_req_addr;
            wdata_r <= i_req_wdata;
         end
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         mem_write_r <= mem_write_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         byte_r      <= byte_s;
         half_r      <= half_s;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_r  <= misalign_s;
`endif
      end
   end

   assign o_req_ready  = (state_r == ST_IDLE);
   assign o_rsp_valid  = rsp_valid_r;
   assign o_rsp_rdata  = rsp_rdata_r;
   // Reset suppresses a pending write in the same cycle, so an aborted double leaves its high word untouched.
   assign o_mem_write  = mem_write_r & ~i_rst;
   assign o_mem_addr   = mem_addr_r;
   assign o_mem_wdata  = mem_wdata_r;
   assign o_store_byte = byte_r;
   assign o_store_half = half_r;
`ifdef LSU_MISALIGN_TRAP_EN
   assign o_misalign   = misalign_r;
`endif

endmodule
